// File: rtl/radar_seq_pkg.sv
// Shared constants for the radar frame sequencer: FSM encodings and datapath widths.
package radar_seq_pkg;

  localparam int CMD_W = 40;
  localparam int FC_W  = 16;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_INIT_REQ   = 4'd1;
  localparam logic [3:0] S_INIT_WAIT  = 4'd2;
  localparam logic [3:0] S_READY      = 4'd3;
  localparam logic [3:0] S_CFG_REQ    = 4'd4;
  localparam logic [3:0] S_CFG_WAIT   = 4'd5;
  localparam logic [3:0] S_CHIRP_REQ  = 4'd6;
  localparam logic [3:0] S_CHIRP_WAIT = 4'd7;
  localparam logic [3:0] S_GAP        = 4'd8;
  localparam logic [3:0] S_ERROR      = 4'd9;

endpackage

// File: rtl/radar_frame_sequencer_sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous level signals into the clk domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/radar_frame_sequencer.sv
// Sequences ADC init, queued ADC register writes and DAC chirp frames onto the SPI driver.
// Optional handshake watchdog enabled by defining RADAR_SEQ_WDOG_EN.
module radar_frame_sequencer
  import radar_seq_pkg::*;
#(
  parameter int CHIRPS         = 64,
  parameter int GAP_CYCLES     = 1024,
  parameter int CFG_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 262143,
  localparam int CIW = (CHIRPS > 1) ? $clog2(CHIRPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             run,
  input  logic             cfg_wr,
  input  logic [CMD_W-1:0] cfg_data,
  output logic             cfg_full,
  output logic             cfg_overflow,
  output logic             drv_init,
  output logic             drv_start_adc,
  output logic             drv_start_dac,
  output logic [CMD_W-1:0] drv_data,
  input  logic             drv_busy,
  output logic             init_done,
  output logic             chirp_active,
  output logic [CIW-1:0]   chirp_idx,
  output logic             frame_done,
  output logic [FC_W-1:0]  frame_count,
  output logic             seq_error
);

  localparam int AW   = $clog2(CFG_DEPTH);
  localparam int PW   = (AW > 0) ? AW : 1;
  localparam int CMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic             busy_s;
  logic [3:0]       state, state_next;
  logic [CW-1:0]    cnt;
  logic             err_en_low;
  logic [CMD_W-1:0] mem [CFG_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             q_empty, push, pop, in_hs, gap_end, last_chirp, wdog_hit;

  sync_2ff #(.W(1)) u_busy_sync (.clk(clk), .rst_n(rst_n), .d(drv_busy), .q(busy_s));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CFG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_empty    = (count == '0);
  assign cfg_full   = (count == (AW+1)'(CFG_DEPTH));
  assign pop        = (state == S_CFG_WAIT) && !busy_s;
  assign push       = cfg_wr && (!cfg_full || pop);
  assign in_hs      = state inside {S_INIT_REQ, S_INIT_WAIT, S_CFG_REQ,
                                    S_CFG_WAIT, S_CHIRP_REQ, S_CHIRP_WAIT};
  assign gap_end    = (cnt == CW'(GAP_CYCLES - 1));
  assign last_chirp = (chirp_idx == CIW'(CHIRPS - 1));

`ifdef RADAR_SEQ_WDOG_EN
  assign wdog_hit = in_hs && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      cfg_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (cfg_wr && !push) cfg_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cfg_data;
  end

  // Waits never bail out on enable: the in-flight driver transaction always completes first.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (enable && !busy_s) state_next = S_INIT_REQ;
      S_INIT_REQ:   if (busy_s) state_next = S_INIT_WAIT;
      S_INIT_WAIT:  if (!busy_s) state_next = S_READY;
      S_READY: begin
        if (enable) begin
          if (!q_empty) state_next = S_CFG_REQ;
          else if (run) state_next = S_CHIRP_REQ;
        end
      end
      S_CFG_REQ:    if (busy_s) state_next = S_CFG_WAIT;
      S_CFG_WAIT:   if (!busy_s) state_next = S_READY;
      S_CHIRP_REQ:  if (busy_s) state_next = S_CHIRP_WAIT;
      S_CHIRP_WAIT: if (!busy_s) state_next = enable ? S_GAP : S_READY;
      S_GAP: begin
        if (!enable) state_next = S_READY;
        else if (gap_end) state_next = last_chirp ? S_READY : S_CHIRP_REQ;
      end
      S_ERROR:      if (err_en_low && enable) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
    if (wdog_hit && (state_next == state)) state_next = S_ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      chirp_idx   <= '0;
      init_done   <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      seq_error   <= 1'b0;
      err_en_low  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= ((state_next != state) || !(in_hs || state == S_GAP)) ? '0 : cnt + 1'b1;
      frame_done <= 1'b0;
      err_en_low <= (state == S_ERROR) && (err_en_low || !enable);
      if (state == S_INIT_WAIT && state_next == S_READY) init_done <= 1'b1;
      if (state == S_ERROR && state_next == S_IDLE) init_done <= 1'b0;
      if (state_next == S_ERROR) seq_error <= 1'b1;
      if (state == S_GAP && state_next == S_CHIRP_REQ) chirp_idx <= chirp_idx + 1'b1;
      else if (state_next == S_READY || state_next == S_ERROR) chirp_idx <= '0;
      if (state == S_GAP && enable && gap_end && last_chirp) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  assign drv_init      = (state == S_INIT_REQ);
  assign drv_start_adc = (state == S_INIT_REQ) || (state == S_CFG_REQ);
  assign drv_start_dac = (state == S_CHIRP_REQ);
  assign chirp_active  = (state == S_CHIRP_REQ) || (state == S_CHIRP_WAIT);
  assign drv_data      = ((state == S_CFG_REQ) || (state == S_CFG_WAIT)) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_radar_frame_sequencer.sv
// Randomized bench for radar_frame_sequencer: driver model, transaction scoreboard, summary.
// Handshake: a start output rises, holds until the driver's busy is seen, then waits for busy to fall.
module tb_radar_frame_sequencer;

  localparam int CHIRPS         = 4;
  localparam int GAP_CYCLES     = 10;
  localparam int CFG_DEPTH      = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam logic [1:0] T_INIT = 2'd1, T_CFG = 2'd2, T_CHIRP = 2'd3;

  logic        clk, rst_n, enable, run, cfg_wr, drv_busy;
  logic [39:0] cfg_data, drv_data;
  logic        cfg_full, cfg_overflow, drv_init, drv_start_adc, drv_start_dac;
  logic        init_done, chirp_active, frame_done, seq_error;
  logic [1:0]  chirp_idx;
  logic [15:0] frame_count;

  logic [45:0] exp_q[$];
  logic [15:0] fc_q[$];
  int checks = 0, errors = 0;
  int frames_model = 0;
  bit drv_hang = 0, drv_hold = 0;
  int fixed_dly = 0, fixed_len = 0, drv_dly, drv_len;
  logic prev_adc = 0, prev_dac = 0;
  logic [39:0] cur_data = '0;
  logic [39:0] w;
  int el, n;

  radar_frame_sequencer #(
    .CHIRPS(CHIRPS), .GAP_CYCLES(GAP_CYCLES), .CFG_DEPTH(CFG_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .run(run), .cfg_wr(cfg_wr),
    .cfg_data(cfg_data), .cfg_full(cfg_full), .cfg_overflow(cfg_overflow),
    .drv_init(drv_init), .drv_start_adc(drv_start_adc), .drv_start_dac(drv_start_dac),
    .drv_data(drv_data), .drv_busy(drv_busy), .init_done(init_done),
    .chirp_active(chirp_active), .chirp_idx(chirp_idx), .frame_done(frame_done),
    .frame_count(frame_count), .seq_error(seq_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(2000000);
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [45:0] txn(input logic [1:0] t, input logic [3:0] idx,
                                      input logic [39:0] d);
    return {t, idx, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond(input int which, input int k);
    case (which)
      0: return drv_busy;
      1: return !drv_busy;
      2: return frame_done;
      3: return chirp_active && (chirp_idx == k[1:0]);
      4: return seq_error;
      5: return (exp_q.size() == 0) && !drv_busy && !chirp_active && !drv_start_adc;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int k,
                          input int budget, output int elapsed);
    for (elapsed = 0; elapsed < budget; elapsed++) begin
      @(negedge clk);
      if (cond(which, k)) break;
    end
    checks++;
    if (elapsed >= budget) begin
      errors++;
      $display("FAIL %s: waited %0d cycles, required event within %0d", name, elapsed, budget);
    end
  endtask

  task automatic step(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int e;
    wait_for(name, 5, 0, 4000, e);
    step(GAP_CYCLES + 12);
  endtask

  task automatic write_cfg(input logic [39:0] d);
    step(1);
    cfg_wr = 1'b1;
    cfg_data = d;
    step(1);
    cfg_wr = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < CHIRPS; i++) exp_q.push_back(txn(T_CHIRP, 4'(i), 40'd0));
    frames_model++;
    fc_q.push_back(16'(frames_model));
  endtask

  function automatic logic [39:0] rand_word();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // driver model: busy rises some cycles after a start request and falls later
  initial begin
    drv_busy = 1'b0;
    forever begin
      @(negedge clk);
      if ((drv_start_adc || drv_start_dac) && !drv_hang) begin
        drv_dly = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 6));
        drv_len = (fixed_len != 0) ? fixed_len : int'($urandom_range(4, 20));
        repeat (drv_dly) @(posedge clk);
        #1 drv_busy = 1'b1;
        repeat (drv_len) @(posedge clk);
        while (drv_hold) @(posedge clk);
        #1 drv_busy = 1'b0;
      end
    end
  end

  // scoreboard monitor
  task automatic compare_txn(input logic [45:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_txn: got %0h with nothing expected at %0t", got, $time);
    end else begin
      check("txn_order", got, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (drv_start_adc && !prev_adc) begin
        cur_data = drv_data;
        compare_txn(drv_init ? txn(T_INIT, 4'd0, 40'd0) : txn(T_CFG, 4'd0, drv_data));
      end else if (drv_start_adc && !drv_init) begin
        check("cfg_data_stable", drv_data, cur_data);
      end
      if (drv_start_dac && !prev_dac) begin
        check("chirp_active_on_req", chirp_active, 1);
        compare_txn(txn(T_CHIRP, {2'b00, chirp_idx}, 40'd0));
      end
      if (frame_done) begin
        if (fc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: frame_count=%0d with no frame expected", frame_count);
        end else begin
          check("frame_count", frame_count, fc_q.pop_front());
          check("chirp_idx_after_frame", chirp_idx, 0);
        end
      end
    end
    prev_adc = drv_start_adc;
    prev_dac = drv_start_dac;
  end

  // stimulus
  initial begin
    rst_n = 1'b0; enable = 1'b0; run = 1'b0; cfg_wr = 1'b0; cfg_data = '0;
    step(3);
    check("rst_drv_start_adc", drv_start_adc, 0);
    check("rst_drv_start_dac", drv_start_dac, 0);
    check("rst_drv_init", drv_init, 0);
    check("rst_drv_data", drv_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_cfg_full", cfg_full, 0);
    check("rst_cfg_overflow", cfg_overflow, 0);
    check("rst_seq_error", seq_error, 0);
    check("rst_chirp_idx", chirp_idx, 0);
    rst_n = 1'b1;
    step(2);

    // init: busy 3 cycles after start, held 40 cycles
    fixed_dly = 3; fixed_len = 40;
    exp_q.push_back(txn(T_INIT, 4'd0, 40'd0));
    enable = 1'b1;
    wait_for("init_busy_rise", 0, 0, 50, el);
    check("init_hold_0", {drv_init, drv_start_adc}, 2'b11);
    @(negedge clk); check("init_hold_1", {drv_init, drv_start_adc}, 2'b11);
    @(negedge clk); check("init_hold_2", {drv_init, drv_start_adc}, 2'b11);
    @(negedge clk); check("init_release", {drv_init, drv_start_adc}, 2'b00);
    wait_for("init_busy_fall", 1, 0, 60, el);
    check("init_done_early0", init_done, 0);
    @(negedge clk); @(negedge clk); check("init_done_early2", init_done, 0);
    @(negedge clk); check("init_done_set", init_done, 1);
    fixed_dly = 0; fixed_len = 0;
    step(2);

    // frame with a write queued during chirp 2, then a second frame
    push_frame();
    run = 1'b1;
    wait_for("wait_chirp2", 3, 2, 2000, el);
    w = 40'h0201C20001;
    exp_q.push_back(txn(T_CFG, 4'd0, w));
    push_frame();
    write_cfg(w);
    wait_for("frame1_done", 2, 0, 2000, el);
    wait_for("frame2_chirp1", 3, 1, 2000, el);
    step(1);
    run = 1'b0;
    wait_for("frame2_done", 2, 0, 2000, el);
    drain("drain_frames");
    check("frame_count_after_two", frame_count, 16'(frames_model));

    // overflow: five writes while the driver holds busy
    check("overflow_clear", cfg_overflow, 0);
    drv_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      w = rand_word();
      cfg_wr = 1'b1;
      cfg_data = w;
      if (i < CFG_DEPTH) exp_q.push_back(txn(T_CFG, 4'd0, w));
    end
    step(1);
    cfg_wr = 1'b0;
    @(negedge clk);
    check("cfg_full_set", cfg_full, 1);
    check("cfg_overflow_set", cfg_overflow, 1);
    step(5);
    drv_hold = 1'b0;
    drain("drain_overflow");
    check("cfg_full_clear", cfg_full, 0);
    check("cfg_overflow_sticky", cfg_overflow, 1);

    // random writes queued ahead of a frame
    for (int k = 0; k < 3; k++) begin
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        w = rand_word();
        exp_q.push_back(txn(T_CFG, 4'd0, w));
        write_cfg(w);
      end
      push_frame();
      run = 1'b1;
      wait_for("rand_chirp0", 3, 0, 2000, el);
      step(1);
      run = 1'b0;
      wait_for("rand_frame_done", 2, 0, 2000, el);
      drain("drain_rand");
    end

    // abort: enable drops during chirp 1
    exp_q.push_back(txn(T_CHIRP, 4'd0, 40'd0));
    exp_q.push_back(txn(T_CHIRP, 4'd1, 40'd0));
    run = 1'b1;
    wait_for("abort_chirp1", 3, 1, 2000, el);
    step(1);
    enable = 1'b0;
    drain("drain_abort");
    step(30);
    check("abort_chirp_idx", chirp_idx, 0);
    check("abort_frame_count", frame_count, 16'(frames_model));
    check("abort_no_dac", drv_start_dac, 0);
    check("abort_init_kept", init_done, 1);
    run = 1'b0;
    step(1);
    enable = 1'b1;
    step(30);
    check("reenable_idle", {drv_start_adc, drv_start_dac, chirp_active}, 3'b000);

`ifdef RADAR_SEQ_WDOG_EN
    // watchdog: driver never answers a queued write
    drv_hang = 1'b1;
    w = rand_word();
    exp_q.push_back(txn(T_CFG, 4'd0, w));
    write_cfg(w);
    wait_for("wdog_trip", 4, 0, TIMEOUT_CYCLES + 8, el);
    check("wdog_latency_ok", (el <= TIMEOUT_CYCLES + 4), 1);
    check("wdog_starts_low", {drv_init, drv_start_adc, drv_start_dac}, 3'b000);
    drv_hang = 1'b0;
    exp_q.push_back(txn(T_INIT, 4'd0, 40'd0));
    exp_q.push_back(txn(T_CFG, 4'd0, w));
    step(3);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    drain("drain_wdog");
    check("wdog_reinit_done", init_done, 1);
    check("wdog_error_sticky", seq_error, 1);
`else
    check("no_wdog_seq_error", seq_error, 0);
`endif

    step(20);
    check("exp_q_empty", exp_q.size(), 0);
    check("fc_q_empty", fc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
